serial_adder: RTL



---
 rtl/serial_adder.sv | 110 +++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  , output logic           ovf
`endif
);

  // Handshake: start is taken only when idle (busy=0); a, b, sub, cin are
  // captured on that edge. done pulses for one cycle when sum/cout update;
  // starts seen while busy are dropped.
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             bit_s;
  logic             bit_c;
  logic             last;
`ifdef SERIAL_ADDER_OVF_EN
  logic             msb_c;
`endif

  assign bit_s = a_sh[0] ^ b_sh[0] ^ carry;
  assign bit_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  assign last  = (cnt == CNT_W'(WIDTH - 1));

  // New sum bit enters at the MSB so the result is aligned after WIDTH shifts.
  always_comb begin
    res_next            = res_sh >> 1;
    res_next[WIDTH-1]   = bit_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      msb_c  <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub ? ~cin : cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          res_sh <= res_next;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= bit_c;
          cnt    <= cnt + 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
          if (last) msb_c <= carry;
`endif
          if (last) state <= DONE;
        end
        DONE: begin
          sum   <= res_sh;
          cout  <= carry;
`ifdef SERIAL_ADDER_OVF_EN
          ovf   <= msb_c ^ carry;
`endif
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
